// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the four-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             hold_expired;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input hold_expired);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output hold_expired);

endinterface

// File: rtl/rr_pick4.sv
// Rotating priority picker: the first set bit of (req & mask) at or after
// position start, wrapping mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   pos;

  // Rotate so start sits at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    masked = req & mask;
    dbl    = {masked, masked};
    rot    = dbl[start +: N_REQ];
    found  = 1'b0;
    pos    = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = IDX_W'(i);
      end else begin
        found = found;
      end
    end
    idx = pos + start;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Locking round-robin arbiter for four requesters with an optional per-owner
// hold-time limit; all grant outputs are registered.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  localparam bit                HOLD_EN   = (MAX_HOLD != 32'sd0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'sd1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = 8'hFF;

  arb_state_t       state_r;
  logic [IDX_W-1:0] last_owner_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [N_REQ-1:0] gnt_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;
  logic             hold_expired_r;

  logic             owner_req_s;
  logic             expiry_s;
  logic [IDX_W-1:0] start_s;
  logic [N_REQ-1:0] mask_s;
  logic             found_s;
  logic [IDX_W-1:0] win_s;

  // The owner is excluded from the pick only when it still requests, i.e. on expiry.
  always_comb begin
    owner_req_s = bus.req[gnt_idx_r];
    expiry_s    = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    start_s     = last_owner_r + 2'd1;
    if ((state_r == ARB_GRANT) && owner_req_s) begin
      mask_s = ~idx_to_onehot(gnt_idx_r);
    end else begin
      mask_s = 4'b1111;
    end
  end

  rr_pick4 u_pick (
    .req   (bus.req),
    .start (start_s),
    .mask  (mask_s),
    .found (found_s),
    .idx   (win_s)
  );

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ARB_IDLE;
      last_owner_r   <= 2'd3;
      hold_cnt_r     <= 8'd0;
      gnt_r          <= 4'b0000;
      gnt_idx_r      <= 2'd0;
      gnt_valid_r    <= 1'b0;
      hold_expired_r <= 1'b0;
    end else begin
      hold_expired_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (found_s) begin
            state_r      <= ARB_GRANT;
            last_owner_r <= win_s;
            hold_cnt_r   <= 8'd0;
            gnt_r        <= idx_to_onehot(win_s);
            gnt_idx_r    <= win_s;
            gnt_valid_r  <= 1'b1;
          end else begin
            gnt_r       <= 4'b0000;
            gnt_idx_r   <= 2'd0;
            gnt_valid_r <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (!owner_req_s) begin
            // Release wins over a coincident expiry: hand off with no pulse.
            if (found_s) begin
              last_owner_r <= win_s;
              hold_cnt_r   <= 8'd0;
              gnt_r        <= idx_to_onehot(win_s);
              gnt_idx_r    <= win_s;
              gnt_valid_r  <= 1'b1;
            end else begin
              state_r     <= ARB_IDLE;
              hold_cnt_r  <= 8'd0;
              gnt_r       <= 4'b0000;
              gnt_idx_r   <= 2'd0;
              gnt_valid_r <= 1'b0;
            end
          end else if (expiry_s) begin
            hold_cnt_r <= 8'd0;
            if (found_s) begin
              last_owner_r   <= win_s;
              gnt_r          <= idx_to_onehot(win_s);
              gnt_idx_r      <= win_s;
              hold_expired_r <= 1'b1;
            end else begin
              gnt_r <= gnt_r;
            end
          end else if (hold_cnt_r != HOLD_SAT) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r     <= ARB_IDLE;
          hold_cnt_r  <= 8'd0;
          gnt_r       <= 4'b0000;
          gnt_idx_r   <= 2'd0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt          = gnt_r;
  assign bus.gnt_idx      = gnt_idx_r;
  assign bus.gnt_valid    = gnt_valid_r;
  assign bus.hold_expired = hold_expired_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: a MAX_HOLD=8 and a MAX_HOLD=0 instance
// driven with directed and random requests against an ownership model.
module tb_rr_arbiter_4;

  typedef struct {
    int owner;   // -1 when idle
    int held;    // cycles the current owner has held the grant
    int last;
    bit pulse;
  } mdl_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   pulses8;
  mdl_t m8;
  mdl_t m0;

  rr_arbiter_4_if bus8 ();
  rr_arbiter_4_if bus0 ();

  rr_arbiter_4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  rr_arbiter_4 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  function automatic int pick(int last, logic [3:0] r, int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int max_hold, logic [3:0] r, logic rst);
    mdl_t n;
    int   w;
    n       = m;
    n.pulse = 1'b0;
    if (!rst) begin
      n.owner = -1; n.held = 0; n.last = 3;
    end else if (m.owner < 0 || !r[m.owner]) begin
      w = pick(m.last, r, -1);
      if (w >= 0) begin n.owner = w; n.last = w; n.held = 1; end
      else begin n.owner = -1; n.held = 0; end
    end else if (max_hold != 0 && m.held == max_hold) begin
      w = pick(m.last, r, m.owner);
      n.held = 1;
      if (w >= 0) begin n.owner = w; n.last = w; n.pulse = 1'b1; end
    end else begin
      n.held = m.held + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(mdl_t m);
    logic [3:0] v;
    v = 4'b0000;
    if (m.owner >= 0) v[m.owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_idx(mdl_t m);
    return (m.owner >= 0) ? 2'(m.owner) : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] r8, input logic [3:0] r0);
    rst_n    = rst;
    bus8.req = r8;
    bus0.req = r0;
    @(posedge clk);
    #1;
    m8 = mdl_next(m8, 8, r8, rst);
    m0 = mdl_next(m0, 0, r0, rst);
    chk("h8_gnt",     8'(bus8.gnt),          8'(exp_gnt(m8)));
    chk("h8_idx",     8'(bus8.gnt_idx),      8'(exp_idx(m8)));
    chk("h8_valid",   8'(bus8.gnt_valid),    8'(m8.owner >= 0));
    chk("h8_expired", 8'(bus8.hold_expired), 8'(m8.pulse));
    chk("h0_gnt",     8'(bus0.gnt),          8'(exp_gnt(m0)));
    chk("h0_idx",     8'(bus0.gnt_idx),      8'(exp_idx(m0)));
    chk("h0_valid",   8'(bus0.gnt_valid),    8'(m0.owner >= 0));
    chk("h0_expired", 8'(bus0.hold_expired), 8'(m0.pulse));
    pulses8 += int'(bus8.hold_expired);
  endtask

  initial begin
    logic [3:0] r8;
    logic [3:0] r0;
    int         exp_cnt;
    clk = 1'b0; rst_n = 1'b0; vectors = 0; miscompares = 0; pulses8 = 0;
    bus8.req = 4'b0000; bus0.req = 4'b0000;
    m8 = '{owner: -1, held: 0, last: 3, pulse: 1'b0};
    m0 = m8;

    // Reset, then idle with no requests.
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 4'b0000);
    chk("idle_gnt", 8'(bus8.gnt), 8'h00);

    // All four requesting: 0,1,2,3 each for 8 cycles, then back to 0.
    pulses8 = 0;
    for (int i = 0; i < 33; i++) step(1'b1, 4'b1111, 4'b0000);
    chk("rr_pulses", 8'(pulses8), 8'd4);
    chk("rr_wrap_idx", 8'(bus8.gnt_idx), 8'd0);

    // Lone requester 2 is never pre-empted.
    step(1'b1, 4'b0000, 4'b0000);
    pulses8 = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0100, 4'b0000);
    chk("solo_pulses", 8'(pulses8), 8'd0);
    chk("solo_idx", 8'(bus8.gnt_idx), 8'd2);

    // Release of owner 1 hands straight to 2 with no idle cycle.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0010, 4'b0000);
    step(1'b1, 4'b0110, 4'b0000);
    chk("pre_rel_idx", 8'(bus8.gnt_idx), 8'd1);
    step(1'b1, 4'b0100, 4'b0000);
    chk("rel_gnt", 8'(bus8.gnt), 8'h04);
    chk("rel_valid", 8'(bus8.gnt_valid), 8'd1);

    // Reset while 3 owns, then 0 wins first after reset.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b1000, 4'b0000);
    step(1'b1, 4'b1000, 4'b0000);
    chk("own3_idx", 8'(bus8.gnt_idx), 8'd3);
    step(1'b0, 4'b1000, 4'b0000);
    chk("rst_gnt", 8'(bus8.gnt), 8'h00);
    step(1'b1, 4'b1001, 4'b0000);
    chk("post_rst_idx", 8'(bus8.gnt_idx), 8'd0);

    // Release coincident with expiry counts as a release.
    step(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0011, 4'b0000);
    step(1'b1, 4'b0010, 4'b0000);
    chk("rel_exp_pulse", 8'(bus8.hold_expired), 8'd0);
    chk("rel_exp_idx", 8'(bus8.gnt_idx), 8'd1);

    // Random traffic on both instances.
    r8 = 4'b0000; r0 = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r8 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r0 = 4'($urandom_range(0, 15));
      step(1'b1, r8, r0);
    end

    // Unlimited hold: requester 0 keeps the grant, counter saturates.
    step(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0000, 4'b0011);
    exp_cnt = (m0.held - 1 > 255) ? 255 : m0.held - 1;
    chk("nolimit_idx", 8'(bus0.gnt_idx), 8'd0);
    chk("nolimit_hold_cnt", dut0.hold_cnt_r, 8'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Round-robin arbiter that shares one downstream resource among four requesters and reports the owner both one-hot and as a 2-bit encoded index, in the same 4-to-2 encoding used by the team's encoder blocks. Grants are locking: an owner keeps the resource until it drops its request or a hold-time limit expires. The block sits between the four request sources and the shared datapath's select/enable inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner; 0 disables the limit; legal range 0–255.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising `clk`.
- `req`  input  4  request lines; `req[i]` held high by requester i while it wants or uses the resource.
- `gnt`  output  4  one-hot grant; all zero when idle; registered.
- `gnt_idx`  output  2  binary index of the owner, with `0` = req[0] through `3` = req[3]; 0 when idle; registered.
- `gnt_valid`  output  1  high when a grant is active; registered.
- `hold_expired`  output  1  one-cycle pulse, registered, when an owner is pre-empted by the hold limit.

## Operation
- States: IDLE and GRANT. Reset enters IDLE.
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `hold_expired`=0.
  - `last_owner`=3, so the first priority goes to req[0].
  - `hold_cnt`=0.
- Priority order on any arbitration is `last_owner+1`, `+2`, `+3`, `+4`, all mod 4. The first asserted request in that order wins.
- IDLE → GRANT: on an edge where `req != 0`. The winner becomes owner, `last_owner` := winner, and `hold_cnt` := 0.
- GRANT, with `req[owner]` high and the limit not reached: hold the grant and increment `hold_cnt`.
- GRANT, with `req[owner]` low (release): re-arbitrate on the same edge among the remaining requests, with no bubble cycle.
  - If a winner exists, it becomes the new owner and `hold_cnt` := 0.
  - Otherwise go to IDLE, with all grant outputs 0.
- GRANT, with `MAX_HOLD != 0`, `hold_cnt == MAX_HOLD-1` and `req[owner]` still high (expiry): arbitrate among the other three requests.
  - If any is asserted, the winner takes the grant, `hold_expired` pulses, and `hold_cnt` := 0.
  - If none is asserted, the current owner keeps the grant, `hold_cnt` := 0, and there is no pulse.
- `hold_cnt` is 8 bits and never wraps past `MAX_HOLD-1`. When `MAX_HOLD=0` it saturates at 255 and is otherwise ignored.
- `gnt`, `gnt_idx` and `gnt_valid` are always mutually consistent: `gnt == (1 << gnt_idx)` when `gnt_valid`, and `gnt == 0` otherwise.

## Timing
- Latency from request to grant is one cycle: a `req` sampled at edge k gives a grant visible after edge k.
- Release latency is one cycle: a `req[owner]` deassert sampled at edge k gives the new grant, or idle, after edge k.
- With requests continuously present, an owner holds the grant for at most `MAX_HOLD` cycles.
- Simultaneous events:
  - A new request arriving on the same edge as a release takes part in that arbitration.
  - Release and expiry on the same edge are treated as a release; `hold_expired` does not pulse.
- A reset asserted mid-grant forces all outputs to their reset values at that edge, regardless of `req`.

## Structure
- Shared package `arb_pkg`:
  - constants `N_REQ=4` and `IDX_W=2`;
  - the state enum `{ARB_IDLE, ARB_GRANT}`;
  - the hold counter width constant `HOLD_W=8`.
- Sub-module `rr_pick4` (combinational):
  - inputs: `req[3:0]`, `start[1:0]`, and a 4-bit `mask` that excludes the owner on expiry;
  - outputs: `found` and `idx[1:0]`;
  - rotates the masked request vector by `start`, applies a fixed priority encode, then un-rotates the result.
- The top level holds the state, `last_owner`, `hold_cnt` and the output registers.

## Test plan
- After reset, drive `req=4'b0000` for 3 cycles → `gnt=0`, `gnt_valid=0`, `gnt_idx=0` on every cycle.
- From idle, drive `req=4'b1111` and hold it, with `MAX_HOLD=8` → owners cycle 0, 1, 2, 3, 0, each for exactly 8 cycles, and `hold_expired` pulses at each hand-off.
- Hold `req[2]` alone for 20 cycles with `MAX_HOLD=8` → `gnt_idx=2` stays continuously and `hold_expired` never pulses.
- req[1] is owner with `req=4'b0110`; drop `req[1]` → on the next cycle `gnt=4'b0100`, `gnt_idx=2`, with no idle cycle between owners.
- Assert `rst_n=0` for one cycle while req[3] is owner → outputs go to 0 after that edge; after reset is released with `req=4'b1001`, the first grant goes to index 0.
- Use `MAX_HOLD=0` with `req=4'b0011` held for 300 cycles → req[0] keeps the grant throughout, `hold_cnt` saturates, and there is no pulse.
